delay_probe: RTL and testbench



---
 rtl/delay_probe.sv | 138 +++++++++++++
 tb/tb_delay_probe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_probe.sv
// Round-trip latency probe: launches a marker word into a delay line after a
// zero flush, then counts cycles until the same word returns or a timeout.
module delay_probe #(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 16,
  parameter int MAX_WAIT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic [DATA_W-1:0] probe_out,
  input  logic [DATA_W-1:0] echo_in,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        delay
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SEND,
    WAIT,
    REPORT
  } state_t;

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] probe_d;
  logic              busy_d, done_d, timeout_d;
  logic [7:0]        delay_d;
  logic              echo_hit;

  assign echo_hit = (echo_in == pat_q);

  // Every output is computed from the next state and registered, so done and
  // timeout are high exactly during the REPORT cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    delay_d   = delay;
    probe_d   = '0;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          delay_d = 8'd0;
          cnt_d   = 8'd0;
          // A zero marker cannot be told apart from the flush value.
          if (pattern == '0) begin
            timeout_d = 1'b1;
            state_d   = REPORT;
          end else begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = 8'd0;
          probe_d = pat_q;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SEND: begin
        if (echo_hit) begin
          delay_d = 8'd0;
          done_d  = 1'b1;
          state_d = REPORT;
        end else begin
          cnt_d   = 8'd1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (echo_hit) begin
          delay_d = cnt_q;
          done_d  = 1'b1;
          state_d = REPORT;
        end else if (cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = REPORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pat_q     <= '0;
      probe_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      delay     <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      probe_out <= probe_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= timeout_d;
      delay     <= delay_d;
    end
  end

endmodule

// File: tb/tb_delay_probe.sv
// Self-checking bench for delay_probe: register-chain and scripted echo sources,
// with expected results derived from the launch/echo timing rules.
module tb_delay_probe;

  localparam int DATA_W     = 8;
  localparam int FLUSH      = 16;
  localparam int MAX_WAIT   = 255;
  localparam int SCRIPT_LEN = 300;
  localparam int CHAIN_MAX  = 12;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] probe_out;
  logic [DATA_W-1:0] echo_in;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [7:0]        delay;

  delay_probe #(
    .DATA_W      (DATA_W),
    .FLUSH_CYCLES(FLUSH),
    .MAX_WAIT    (MAX_WAIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pattern  (pattern),
    .probe_out(probe_out),
    .echo_in  (echo_in),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .delay    (delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Echo sources: mode 0 = register chain of 'depth' stages (0 = wire),
  // mode 1 = scripted word per cycle, index 0 aligned with the SEND cycle.
  int          mode  = 0;
  int          depth = 0;
  int          cyc   = 0;
  int          e0    = 0;
  int          script_idx;
  logic [7:0]  script [0:SCRIPT_LEN-1];
  logic [7:0]  chain  [1:CHAIN_MAX];
  logic [7:0]  echo_chain, echo_script;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    chain[1] <= probe_out;
    for (int i = 2; i <= CHAIN_MAX; i++) chain[i] <= chain[i-1];
  end

  assign script_idx  = cyc - e0 - FLUSH;
  assign echo_chain  = (depth == 0) ? probe_out : chain[depth];
  assign echo_script = (script_idx >= 0 && script_idx < SCRIPT_LEN) ? script[script_idx] : 8'h00;
  assign echo_in     = (mode == 0) ? echo_chain : echo_script;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_script();
    for (int j = 0; j < SCRIPT_LEN; j++) script[j] = 8'h00;
  endtask

  // Reference: the first cycle d after launch where the echo equals the marker
  // gives delay d and done in cycle F+d+2; no hit within MAX_WAIT is a timeout
  // in cycle F+MAX_WAIT+2; a zero marker times out in cycle 1.
  function automatic void predict(input logic [7:0] pat, output int exp_done,
                                  output int exp_to, output int exp_delay);
    int hit;
    hit       = -1;
    exp_done  = -1;
    exp_to    = -1;
    exp_delay = 0;
    if (pat == 8'h00) begin
      exp_to = 1;
    end else begin
      if (mode == 0) hit = depth;
      else
        for (int j = 0; j <= MAX_WAIT && j < SCRIPT_LEN; j++)
          if (hit < 0 && script[j] == pat) hit = j;
      if (hit >= 0 && hit <= MAX_WAIT) begin
        exp_done  = FLUSH + hit + 2;
        exp_delay = hit;
      end else begin
        exp_to = FLUSH + MAX_WAIT + 2;
      end
    end
  endfunction

  // One measurement. Cycle k is the k-th cycle after the accepting edge; the
  // bench samples in its middle. ra/rb are cycles in which start is re-pulsed.
  task automatic measure(input string name, input logic [7:0] pat,
                         input int ra, input int rb);
    int exp_done, exp_to, exp_delay, exp_report;
    int k, done_at, to_at, done_n, to_n, both, nz_n, nz_at, nz_val, idle_at, busy1;
    int budget;
    predict(pat, exp_done, exp_to, exp_delay);
    exp_report = (exp_done >= 0) ? exp_done : exp_to;
    budget  = FLUSH + MAX_WAIT + 10;
    k       = 0;
    done_at = -1; to_at = -1; done_n = 0; to_n = 0; both = 0;
    nz_n    = 0;  nz_at = -1; nz_val = 0; idle_at = -1; busy1 = -1;

    @(negedge clk);
    start   = 1'b1;
    pattern = pat;
    e0      = cyc + 1;
    while (k < budget && idle_at < 0) begin
      @(negedge clk);
      k++;
      start   = (k == ra || k == rb);
      pattern = 8'($urandom);
      if (k == 1) busy1 = int'(busy);
      if (done)    begin done_n++; done_at = k; end
      if (timeout) begin to_n++;   to_at   = k; end
      if (done && timeout) both++;
      if (probe_out != 8'h00) begin nz_n++; nz_at = k; nz_val = int'(probe_out); end
      if (!busy) idle_at = k;
    end
    start = 1'b0;

    check({name, ".done_at"},    done_at, exp_done);
    check({name, ".timeout_at"}, to_at,   exp_to);
    check({name, ".pulses"},     done_n + to_n, 1);
    check({name, ".overlap"},    both, 0);
    check({name, ".delay"},      int'(delay), exp_delay);
    check({name, ".busy_first"}, busy1, 1);
    check({name, ".idle_at"},    idle_at, exp_report + 1);
    check({name, ".launch_n"},   nz_n, (pat != 8'h00) ? 1 : 0);
    if (pat != 8'h00) begin
      check({name, ".launch_at"},  nz_at, FLUSH + 1);
      check({name, ".launch_val"}, nz_val, int'(pat));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".busy"},      int'(busy), 0);
    check({name, ".done"},      int'(done), 0);
    check({name, ".timeout"},   int'(timeout), 0);
    check({name, ".probe_out"}, int'(probe_out), 0);
    check({name, ".delay"},     int'(delay), 0);
  endtask

  initial begin
    logic [7:0] rp;
    int tgt;
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    clear_script();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = 0; depth = 0;
    measure("loopback", 8'hA5, -1, -1);

    depth = 3;
    measure("chain3", 8'h3C, -1, -1);

    mode = 1; clear_script();
    measure("echo_zero", 8'h77, -1, -1);

    mode = 0; depth = 0;
    measure("zero_pat", 8'h00, -1, -1);

    measure("loop_restart", 8'hA5, 5, 12);
    depth = 3;
    measure("chain_restart", 8'h3C, 5, FLUSH + 3);

    mode = 1; clear_script();
    script[2] = 8'hA4;
    script[5] = 8'hA5;
    measure("partial", 8'hA5, -1, -1);

    // Reset while waiting for an echo that never comes.
    clear_script();
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (FLUSH + 10) @(negedge clk);
    check("mid_wait.busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_wait_rst");
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    mode = 0; depth = 0;
    measure("after_rst", 8'hA5, -1, -1);

    for (int r = 0; r < 4; r++) begin
      mode  = 0;
      depth = $urandom_range(0, CHAIN_MAX);
      measure("rand_chain", 8'($urandom_range(1, 255)), -1, -1);
    end

    for (int r = 0; r < 4; r++) begin
      mode = 1;
      rp   = 8'($urandom_range(1, 255));
      tgt  = (r == 3) ? SCRIPT_LEN : $urandom_range(0, 60);
      for (int j = 0; j < SCRIPT_LEN; j++) begin
        script[j] = 8'($urandom);
        if (script[j] == rp) script[j] = ~rp;
      end
      if (tgt < SCRIPT_LEN) script[tgt] = rp;
      measure("rand_script", rp, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
